ay_bus_responder: RTL and testbench

- Responder end of the AY-3-8910/YM2149 BDIR/BC1/BC2 register bus, clocked in the clk28 domain.
- Decodes bus phases (inactive/latch/write/read) and holds the 16-entry PSG register file.
- Returns read data and emits per-register write strobes (envelope restart, port writes).
- Sits behind the CPU port decoder, replacing or shadowing a soft PSG core.
- Used for register snooping, save-state, and as the register front-end of a new tone generator.

---
 rtl/ay_pkg.sv | 48 ++++
 rtl/ay_regfile.sv | 42 ++++
 rtl/ay_bus_responder.sv | 123 ++++++++++++
 tb/tb_ay_bus_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-8910/YM2149 bus responder.
//   - bus mode enum and the {bdir,bc2,bc1} decode function
//   - register index constants
//   - per-register write mask table and the stored-value helper
// Optional build macro: AY_RAW_READBACK_EN (store full bytes, mask only toward consumers).
package ay_pkg;

  typedef enum logic [1:0] {
    AY_IDLE  = 2'd0,
    AY_LATCH = 2'd1,
    AY_WRITE = 2'd2,
    AY_READ  = 2'd3
  } ay_mode_e;

  localparam int unsigned AY_NUM_REGS    = 16;
  localparam logic [3:0]  AY_R_MIXER     = 4'd7;
  localparam logic [3:0]  AY_R_AMP_A     = 4'd8;
  localparam logic [3:0]  AY_R_ENV_SHAPE = 4'd13;
  localparam logic [3:0]  AY_R_PORT_A    = 4'd14;
  localparam logic [3:0]  AY_R_PORT_B    = 4'd15;

  // Index 15 first, index 0 last.
  localparam logic [15:0][7:0] AY_REG_MASK = {
    8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
    8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  function automatic ay_mode_e ay_decode(input logic bdir, input logic bc2, input logic bc1);
    ay_mode_e m;
    case ({bdir, bc2, bc1})
      3'b001, 3'b100, 3'b111: m = AY_LATCH;
      3'b011:                 m = AY_READ;
      3'b110:                 m = AY_WRITE;
      default:                m = AY_IDLE;
    endcase
    return m;
  endfunction

  // Value the register file holds after a write of d to register idx.
  function automatic logic [7:0] ay_stored(input logic [3:0] idx, input logic [7:0] d);
`ifdef AY_RAW_READBACK_EN
    return d | (8'h00 & {4'h0, idx});
`else
    return d & AY_REG_MASK[idx];
`endif
  endfunction

endpackage

// File: rtl/ay_regfile.sv
// 16x8 PSG register file with masked write and asynchronous read mux.
//   clk_i, rst_ni : clock, async active-low reset (all registers clear to 0)
//   we_i, waddr_i, wdata_i : write port (value stored via ay_stored)
//   raddr_i, rdata_o       : async read of the stored byte
//   regs_o                 : flattened masked register view, reg N at [8N+7:8N]
// With AY_RAW_READBACK_EN the full byte is stored and masking happens on regs_o only.
module ay_regfile (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [3:0]   waddr_i,
  input  logic [7:0]   wdata_i,
  input  logic [3:0]   raddr_i,
  output logic [7:0]   rdata_o,
  output logic [127:0] regs_o
);
  import ay_pkg::*;

  logic [15:0][7:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= ay_stored(waddr_i, wdata_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef AY_RAW_READBACK_EN
      regs_o[i*8 +: 8] = mem_q[i] & AY_REG_MASK[i];
`else
      regs_o[i*8 +: 8] = mem_q[i];
`endif
    end
  end

endmodule

// File: rtl/ay_bus_responder.sv
// Responder end of the AY-3-8910/YM2149 BDIR/BC1/BC2 bus in the clk28 domain.
//   clk28, rst_n        : clock, async active-low reset
//   bdir, bc1, bc2      : bus control (bc2 tied high for 2-wire mode)
//   a8                  : chip select, compared against CHIP_ID
//   di                  : address/data from the CPU side
//   d_out, d_out_active : registered read data and its drive enable (8'hFF when idle)
//   regs                : flattened register file, reg N at [8N+7:8N]
//   wr_stb, wr_addr     : one-cycle commit pulse and committed register index
//   env_restart         : one-cycle pulse on any commit to R13
// Parameters: ADDR_HI (upper address nibble to accept), CHIP_ID (a8 level to respond to).
// Optional build macro: AY_RAW_READBACK_EN (YM2149-style raw readback).
module ay_bus_responder #(
  parameter logic [3:0] ADDR_HI = 4'h0,
  parameter logic       CHIP_ID = 1'b0
) (
  input  logic         clk28,
  input  logic         rst_n,
  input  logic         bdir,
  input  logic         bc1,
  input  logic         bc2,
  input  logic         a8,
  input  logic [7:0]   di,
  output logic [7:0]   d_out,
  output logic         d_out_active,
  output logic [127:0] regs,
  output logic         wr_stb,
  output logic [3:0]   wr_addr,
  output logic         env_restart
);
  import ay_pkg::*;

  localparam logic [1:0] StIdle  = AY_IDLE;
  localparam logic [1:0] StLatch = AY_LATCH;
  localparam logic [1:0] StWrite = AY_WRITE;
  localparam logic [1:0] StRead  = AY_READ;

  logic [1:0] state_q, mode;
  logic [3:0] addr_q, addr_d;
  logic       addr_valid_q, addr_valid_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_out_active_q, d_out_active_d;
  logic       wr_stb_q, env_restart_q;
  logic [3:0] wr_addr_q;
  logic       sel, commit, read_en;
  logic [7:0] rf_rdata;

  assign sel = (a8 == CHIP_ID);

  // A deselected chip still sees latches so a foreign latch invalidates our address.
  always_comb begin
    mode = ay_decode(bdir, bc2, bc1);
    if (!sel && mode != StLatch) mode = StIdle;
  end

  // Commit happens on the first cycle the bus leaves WRITE.
  assign commit  = (state_q == StWrite) && (mode != StWrite) && addr_valid_q;
  assign read_en = (mode == StRead) && addr_valid_q;

  always_comb begin
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    if (mode == StLatch) begin
      if (sel && di[7:4] == ADDR_HI) begin
        addr_d       = di[3:0];
        addr_valid_d = 1'b1;
      end else begin
        addr_valid_d = 1'b0;
      end
    end
  end

  assign wdata_d = (mode == StWrite) ? di : wdata_q;

  // Forward a same-cycle commit so WRITE->READ returns the new value.
  always_comb begin
    d_out_active_d = read_en;
    d_out_d        = 8'hFF;
    if (read_en) d_out_d = commit ? ay_stored(addr_q, wdata_q) : rf_rdata;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      addr_valid_q   <= 1'b0;
      wdata_q        <= '0;
      d_out_q        <= 8'hFF;
      d_out_active_q <= 1'b0;
      wr_stb_q       <= 1'b0;
      wr_addr_q      <= '0;
      env_restart_q  <= 1'b0;
    end else begin
      state_q        <= mode;
      addr_q         <= addr_d;
      addr_valid_q   <= addr_valid_d;
      wdata_q        <= wdata_d;
      d_out_q        <= d_out_d;
      d_out_active_q <= d_out_active_d;
      wr_stb_q       <= commit;
      if (commit) wr_addr_q <= addr_q;
      env_restart_q  <= commit && (addr_q == AY_R_ENV_SHAPE);
    end
  end

  ay_regfile u_regfile (
    .clk_i   (clk28),
    .rst_ni  (rst_n),
    .we_i    (commit),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (rf_rdata),
    .regs_o  (regs)
  );

  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;
  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;
  assign env_restart  = env_restart_q;

endmodule

// File: tb/tb_ay_bus_responder.sv
// Self-checking bench for ay_bus_responder: directed vector table plus random bus traffic
// compared cycle by cycle against a behavioural register-bus model.
module tb_ay_bus_responder;

  localparam logic [3:0] ADDR_HI = 4'h0;
  localparam logic       CHIP_ID = 1'b0;
`ifdef AY_RAW_READBACK_EN
  localparam bit RAW = 1'b1;
`else
  localparam bit RAW = 1'b0;
`endif

  // {bdir,bc2,bc1} encodings
  localparam logic [2:0] IDL = 3'b010;
  localparam logic [2:0] LAT = 3'b111;
  localparam logic [2:0] WRT = 3'b110;
  localparam logic [2:0] RD  = 3'b011;

  localparam int MI = 0, ML = 1, MW = 2, MR = 3;

  logic         clk28 = 1'b0;
  logic         rst_n;
  logic         bdir, bc1, bc2, a8;
  logic [7:0]   di;
  logic [7:0]   d_out;
  logic         d_out_active;
  logic [127:0] regs;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic         env_restart;

  int total = 0;
  int bad   = 0;

  ay_bus_responder #(.ADDR_HI(ADDR_HI), .CHIP_ID(CHIP_ID)) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bdir         (bdir),
    .bc1          (bc1),
    .bc2          (bc2),
    .a8           (a8),
    .di           (di),
    .d_out        (d_out),
    .d_out_active (d_out_active),
    .regs         (regs),
    .wr_stb       (wr_stb),
    .wr_addr      (wr_addr),
    .env_restart  (env_restart)
  );

  always #5 clk28 = ~clk28;

  // ---------------- reference model ----------------
  logic [7:0] m_mem [16];
  logic [3:0] m_addr;
  bit         m_av;
  logic [7:0] m_wd;
  int         m_prev;
  bit         e_stb, e_env, e_act;
  logic [3:0] e_waddr;
  logic [7:0] e_dout;

  function automatic logic [7:0] mask_of(int r);
    if (r == 1 || r == 3 || r == 5 || r == 13) return 8'h0F;
    if (r == 6 || r == 8 || r == 9 || r == 10) return 8'h1F;
    return 8'hFF;
  endfunction

  function automatic int bus_mode(logic [2:0] c);
    if (c == 3'b110) return MW;
    if (c == 3'b011) return MR;
    if (c == 3'b001 || c == 3'b100 || c == 3'b111) return ML;
    return MI;
  endfunction

  function automatic logic [127:0] model_regs();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_mem[i] & mask_of(i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_addr = 4'h0; m_av = 1'b0; m_wd = 8'h00; m_prev = MI;
    e_stb = 1'b0; e_env = 1'b0; e_act = 1'b0; e_waddr = 4'h0; e_dout = 8'hFF;
  endtask

  // Outcome of the bus cycle whose inputs are currently applied.
  task automatic model_step();
    int m;
    bit sel;
    sel = (a8 == CHIP_ID);
    m = bus_mode({bdir, bc2, bc1});
    if (!sel && m != ML) m = MI;
    e_stb = (m_prev == MW) && (m != MW) && m_av;
    e_env = e_stb && (m_addr == 4'd13);
    if (e_stb) begin
      e_waddr = m_addr;
      m_mem[m_addr] = RAW ? m_wd : (m_wd & mask_of(m_addr));
    end
    e_act  = (m == MR) && m_av;
    e_dout = e_act ? m_mem[m_addr] : 8'hFF;
    if (m == ML) begin
      if (sel && di[7:4] == ADDR_HI) begin
        m_addr = di[3:0];
        m_av   = 1'b1;
      end else begin
        m_av = 1'b0;
      end
    end
    if (m == MW) m_wd = di;
    m_prev = m;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m.wr_stb", 128'(wr_stb), 128'(e_stb));
    chk("m.env_restart", 128'(env_restart), 128'(e_env));
    chk("m.d_out_active", 128'(d_out_active), 128'(e_act));
    chk("m.d_out", 128'(d_out), 128'(e_dout));
    chk("m.regs", regs, model_regs());
    if (e_stb) chk("m.wr_addr", 128'(wr_addr), 128'(e_waddr));
  endtask

  task automatic cyc(input logic [2:0] md, input logic s, input logic [7:0] d);
    {bdir, bc2, bc1} = md;
    a8 = s;
    di = d;
    @(posedge clk28);
    model_step();
    #1;
    chk_model();
  endtask

  task automatic reset_pulse();
    {bdir, bc2, bc1} = IDL;
    a8 = CHIP_ID;
    di = 8'h00;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst.regs", regs, 128'h0);
    chk("rst.d_out", 128'(d_out), 128'hFF);
    chk("rst.d_out_active", 128'(d_out_active), 128'h0);
    chk("rst.wr_stb", 128'(wr_stb), 128'h0);
    chk("rst.env_restart", 128'(env_restart), 128'h0);
    @(negedge clk28);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] md;
    logic       s;
    logic [7:0] d;
    logic       stb;
    logic [3:0] wa;
    logic       env;
    logic       act;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [2:0] md, input logic s, input logic [7:0] d, input logic stb,
                     input logic [3:0] wa, input logic env, input logic act,
                     input logic [7:0] dout);
    vec_t v;
    v.md = md; v.s = s; v.d = d; v.stb = stb; v.wa = wa; v.env = env; v.act = act;
    v.dout = dout;
    tv.push_back(v);
  endtask

  initial begin
    logic [7:0] r1_read;
    rst_n = 1'b0;
    {bdir, bc2, bc1} = IDL;
    a8 = 1'b0;
    di = 8'h00;
    model_reset();
    repeat (3) @(posedge clk28);
    #1;
    chk("reset.regs", regs, 128'h0);
    chk("reset.d_out", 128'(d_out), 128'hFF);
    chk("reset.d_out_active", 128'(d_out_active), 128'h0);
    chk("reset.wr_stb", 128'(wr_stb), 128'h0);
    @(negedge clk28);
    rst_n = 1'b1;

    r1_read = RAW ? 8'hFF : 8'h0F;
    //   mode s  di     stb wa    env act dout
    add(RD,  0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);   // read with no valid address
    add(LAT, 0, 8'h07, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'h11, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'h22, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'h3F, 0, 4'd0,  0,  0, 8'hFF);
    add(IDL, 0, 8'h00, 1, 4'd7,  0,  0, 8'hFF);   // single commit, last value
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(LAT, 0, 8'h01, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'hFF, 0, 4'd0,  0,  0, 8'hFF);
    add(LAT, 0, 8'h01, 1, 4'd1,  0,  0, 8'hFF);   // commit alongside new latch
    add(RD,  0, 8'h00, 0, 4'd0,  0,  1, r1_read);
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(LAT, 0, 8'h0D, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'h0E, 0, 4'd0,  0,  0, 8'hFF);
    add(IDL, 0, 8'h00, 1, 4'd13, 1,  0, 8'hFF);
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'h0E, 0, 4'd0,  0,  0, 8'hFF);
    add(IDL, 0, 8'h00, 1, 4'd13, 1,  0, 8'hFF);   // same-value rewrite restarts again
    add(RD,  0, 8'h00, 0, 4'd0,  0,  1, 8'h0E);
    add(LAT, 0, 8'h02, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 0, 8'h5A, 0, 4'd0,  0,  0, 8'hFF);
    add(RD,  0, 8'h00, 1, 4'd2,  0,  1, 8'h5A);   // write then read back-to-back
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(LAT, 0, 8'h15, 0, 4'd0,  0,  0, 8'hFF);   // wrong upper nibble
    add(WRT, 0, 8'hAA, 0, 4'd0,  0,  0, 8'hFF);
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(RD,  0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(LAT, 0, 8'h03, 0, 4'd0,  0,  0, 8'hFF);
    add(WRT, 1, 8'h77, 0, 4'd0,  0,  0, 8'hFF);   // deselected write
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);
    add(RD,  1, 8'h00, 0, 4'd0,  0,  0, 8'hFF);   // deselected read
    add(RD,  0, 8'h00, 0, 4'd0,  0,  1, 8'h00);
    add(IDL, 0, 8'h00, 0, 4'd0,  0,  0, 8'hFF);

    foreach (tv[i]) begin
      cyc(tv[i].md, tv[i].s, tv[i].d);
      chk($sformatf("v%0d.wr_stb", i), 128'(wr_stb), 128'(tv[i].stb));
      chk($sformatf("v%0d.env", i), 128'(env_restart), 128'(tv[i].env));
      chk($sformatf("v%0d.act", i), 128'(d_out_active), 128'(tv[i].act));
      chk($sformatf("v%0d.d_out", i), 128'(d_out), 128'(tv[i].dout));
      if (tv[i].stb) chk($sformatf("v%0d.wr_addr", i), 128'(wr_addr), 128'(tv[i].wa));
    end
    chk("dir.r7", 128'(regs[63:56]), 128'h3F);
    chk("dir.r1", 128'(regs[15:8]), 128'h0F);
    chk("dir.r2", 128'(regs[23:16]), 128'h5A);
    chk("dir.r3", 128'(regs[31:24]), 128'h00);

    // Reset asserted in the middle of a write burst.
    cyc(LAT, 0, 8'h04);
    cyc(WRT, 0, 8'h99);
    cyc(WRT, 0, 8'h98);
    reset_pulse();
    cyc(IDL, 0, 8'h00);
    chk("midrst.wr_stb", 128'(wr_stb), 128'h0);
    cyc(IDL, 0, 8'h00);
    chk("midrst.r4", 128'(regs[39:32]), 128'h00);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic [2:0] md;
      logic       s;
      logic [7:0] d;
      if (i % 250 == 249) reset_pulse();
      md = 3'($urandom_range(0, 7));
      s  = ($urandom_range(0, 7) == 0) ? ~CHIP_ID : CHIP_ID;
      d  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:4] = ADDR_HI;
      cyc(md, s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
